// File: rtl/localizer_pkg.sv
// Shared definitions for the Localizer IP datapath blocks.
//   DW_DEF / IW_DEF  default timestamp and sensor-index widths
//   SENTINEL         timestamp value meaning "no hit"
//   NO_IDX           index value for an unfilled ranking slot
//   frame_state_t    state encoding of the frame builder FSM
package localizer_pkg;

    localparam int DW_DEF = 16;
    localparam int IW_DEF = 4;

    localparam logic [15:0] SENTINEL = 16'hFFFF;
    localparam logic [3:0]  NO_IDX   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } frame_state_t;

endpackage

// File: rtl/sensor_frame_builder_top_n_insert.sv
// top_n_insert: registered list of the N smallest (value, id) pairs, kept
// sorted ascending by value. One entry can be inserted per cycle; a new
// entry only displaces entries with a strictly larger value, so on equal
// values the earlier entry keeps the lower rank.
// Ports:
//   clk, rst            clock, async active-high reset
//   clear               empty the list (all slots back to all-ones)
//   ins_valid           insert ins_value / ins_id this cycle
//   ins_value, ins_id   entry to insert
//   ids                 ids of the list, slot 0 = smallest value
module top_n_insert
    import localizer_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = DW_DEF,
    parameter int IW = IW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            ins_valid,
    input  logic [DW-1:0]   ins_value,
    input  logic [IW-1:0]   ins_id,
    output logic [IW*N-1:0] ids
);

    logic [DW-1:0] val_q [N];
    logic [IW-1:0] id_q  [N];
    logic [DW-1:0] val_d [N];
    logic [IW-1:0] id_d  [N];
    logic [N-1:0]  lt;

    // lt is monotonic over a sorted list: the first set bit is where the
    // new entry lands, every later slot takes its predecessor's entry.
    for (genvar j = 0; j < N; j++) begin : g_slot
        assign lt[j] = ins_value < val_q[j];
        if (j == 0) begin : g_head
            assign val_d[j] = lt[j] ? ins_value : val_q[j];
            assign id_d[j]  = lt[j] ? ins_id    : id_q[j];
        end else begin : g_tail
            assign val_d[j] = !lt[j] ? val_q[j] : (lt[j-1] ? val_q[j-1] : ins_value);
            assign id_d[j]  = !lt[j] ? id_q[j]  : (lt[j-1] ? id_q[j-1]  : ins_id);
        end
        assign ids[j*IW +: IW] = id_q[j];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < N; j++) begin
                val_q[j] <= '1;
                id_q[j]  <= '1;
            end
        end else if (clear) begin
            for (int j = 0; j < N; j++) begin
                val_q[j] <= '1;
                id_q[j]  <= '1;
            end
        end else if (ins_valid) begin
            for (int j = 0; j < N; j++) begin
                val_q[j] <= val_d[j];
                id_q[j]  <= id_d[j];
            end
        end
    end

endmodule

// File: rtl/sensor_frame_builder.sv
// sensor_frame_builder: gathers per-sensor arrival timestamps into a frame,
// tracks the N earliest arrivals and presents the closed frame to
// nearest_neighbour with a one-cycle out_valid strobe. Outputs are held
// until the next strobe.
// Ports:
//   clk, rst                 clock, async active-high reset
//   s_valid/s_ready          sample handshake
//   s_id, s_data             sensor index and timestamp of the sample
//   data_out                 held frame timestamps, slot i = sensor i
//   out_indices              constant i at position i
//   min_indices              sensor ids of the N smallest timestamps
//   out_valid                frame strobe
//   frame_partial            held frame was closed by timeout
//   drop_err                 pulse for a discarded sample
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | buffer empty (all sentinel), waiting for a hit
// ST_COLLECT | frame being assembled, timeout running
// ST_EMIT    | one cycle: frame copied out, buffer cleared
module sensor_frame_builder
    import localizer_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int NUM_SENSORS = 12,
    parameter int N           = 3,
    parameter int IW          = IW_DEF,
    parameter int TIMEOUT     = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [IW-1:0]             s_id,
    input  logic [DW-1:0]             s_data,
    output logic [DW*NUM_SENSORS-1:0] data_out,
    output logic [IW*NUM_SENSORS-1:0] out_indices,
    output logic [IW*N-1:0]           min_indices,
    output logic                      out_valid,
    output logic                      frame_partial,
    output logic                      drop_err
);

    localparam int TW = $clog2(TIMEOUT);
    // The accepting cycle counts as cycle 0 of the window, so the timer
    // reaches terminal count TIMEOUT-1 cycles after the first sample.
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 2);

    frame_state_t state_q, state_d;

    logic [DW-1:0]          frame_q [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] seen_q;
    logic [NUM_SENSORS-1:0] sel;
    logic [NUM_SENSORS-1:0] hit;
    logic [TW-1:0]          tmr_q;
    logic [IW*N-1:0]        top_ids;

    logic accept, id_ok, dup, good, complete, tmr_tc;
    logic tmr_load, partial_d, partial_q;

    assign s_ready = (state_q != ST_EMIT) && !rst;
    assign accept  = s_valid && s_ready;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            sel[i] = (s_id == IW'(i));
        end
    end

    // An id outside the frame decodes to no slot at all.
    assign id_ok    = |sel;
    assign dup      = |(sel & seen_q);
    assign good     = accept && id_ok && !dup;
    assign hit      = good ? sel : '0;
    assign complete = &(seen_q | hit);
    assign tmr_tc   = (tmr_q == '0);

    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        partial_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (good) begin
                    tmr_load = 1'b1;
                    state_d  = complete ? ST_EMIT : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // completion wins over a coincident timeout
                if (complete) begin
                    state_d = ST_EMIT;
                end else if (tmr_tc) begin
                    state_d   = ST_EMIT;
                    partial_d = 1'b1;
                end
            end
            ST_EMIT: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            tmr_q         <= '0;
            partial_q     <= 1'b0;
            seen_q        <= '0;
            drop_err      <= 1'b0;
            out_valid     <= 1'b0;
            frame_partial <= 1'b0;
            data_out      <= '1;
            min_indices   <= '1;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                frame_q[i] <= '1;
            end
        end else begin
            state_q   <= state_d;
            drop_err  <= accept && !good;
            out_valid <= (state_q == ST_EMIT);

            if (tmr_load) begin
                tmr_q <= TMR_LOAD;
            end else if (state_q == ST_COLLECT && !tmr_tc) begin
                tmr_q <= tmr_q - TW'(1);
            end

            if (state_d == ST_EMIT && state_q != ST_EMIT) begin
                partial_q <= partial_d;
            end

            if (state_q == ST_EMIT) begin
                seen_q        <= '0;
                min_indices   <= top_ids;
                frame_partial <= partial_q;
                for (int i = 0; i < NUM_SENSORS; i++) begin
                    data_out[i*DW +: DW] <= frame_q[i];
                    frame_q[i]           <= '1;
                end
            end else begin
                seen_q <= seen_q | hit;
                for (int i = 0; i < NUM_SENSORS; i++) begin
                    if (hit[i]) begin
                        frame_q[i] <= s_data;
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_idx
        assign out_indices[i*IW +: IW] = IW'(i);
    end

    top_n_insert #(
        .N  (N),
        .DW (DW),
        .IW (IW)
    ) u_top_n (
        .clk       (clk),
        .rst       (rst),
        .clear     (state_q == ST_EMIT),
        .ins_valid (good),
        .ins_value (s_data),
        .ins_id    (s_id),
        .ids       (top_ids)
    );

endmodule

// File: tb/tb_sensor_frame_builder.sv
module tb_sensor_frame_builder;

    localparam int DW = 16;
    localparam int NS = 12;
    localparam int N  = 3;
    localparam int IW = 4;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [IW-1:0]     s_id = '0;
    logic [DW-1:0]     s_data = '0;
    logic [DW*NS-1:0]  data_out;
    logic [IW*NS-1:0]  out_indices;
    logic [IW*N-1:0]   min_indices;
    logic              out_valid;
    logic              frame_partial;
    logic              drop_err;

    sensor_frame_builder #(
        .DW(DW), .NUM_SENSORS(NS), .N(N), .IW(IW), .TIMEOUT(TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_id          (s_id),
        .s_data        (s_data),
        .data_out      (data_out),
        .out_indices   (out_indices),
        .min_indices   (min_indices),
        .out_valid     (out_valid),
        .frame_partial (frame_partial),
        .drop_err      (drop_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [DW*NS-1:0] data;
        logic [IW*N-1:0]  mins;
        logic             part;
        int               cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;

    // reference model of the frame being assembled
    logic [DW-1:0] m_data [NS];
    bit            m_seen [NS];
    int            m_val_q[$];
    int            m_id_q[$];
    bit            m_open = 0;
    int            f_cyc  = 0;
    int            exp_drops = 0;
    int            obs_drops = 0;
    int            ready_low = 0;
    int            frames_seen = 0;

    task automatic model_clear();
        for (int i = 0; i < NS; i++) begin
            m_data[i] = '1;
            m_seen[i] = 0;
        end
        m_val_q.delete();
        m_id_q.delete();
        m_open = 0;
    endtask

    // rank arrivals by value, ties resolved by arrival order
    function automatic logic [IW*N-1:0] model_mins();
        logic [IW*N-1:0] r;
        bit used [NS];
        r = '1;
        for (int j = 0; j < NS; j++) used[j] = 0;
        for (int k = 0; k < N; k++) begin
            int best;
            best = -1;
            for (int j = 0; j < m_val_q.size(); j++) begin
                if (!used[j] && (best < 0 || m_val_q[j] < m_val_q[best])) best = j;
            end
            if (best >= 0) begin
                used[best] = 1;
                r[k*IW +: IW] = IW'(m_id_q[best]);
            end
        end
        return r;
    endfunction

    task automatic model_push(input bit part, input int c);
        exp_t e;
        for (int i = 0; i < NS; i++) e.data[i*DW +: DW] = m_data[i];
        e.mins = model_mins();
        e.part = part;
        e.cyc  = c;
        exp_q.push_back(e);
        model_clear();
    endtask

    task automatic model_accept(input int id, input int ts, input int c);
        bit all;
        if (id >= NS || m_seen[id]) begin
            exp_drops++;
        end else begin
            if (!m_open) begin
                m_open = 1;
                f_cyc  = c;
            end
            m_data[id] = DW'(ts);
            m_seen[id] = 1;
            m_val_q.push_back(ts);
            m_id_q.push_back(id);
            all = 1;
            for (int i = 0; i < NS; i++) if (!m_seen[i]) all = 0;
            if (all) model_push(0, c + 2);
        end
    endtask

    task automatic send(input int id, input int ts);
        int tries;
        tries = 0;
        while (!s_ready && tries < 4) begin
            @(posedge clk); #1;
            tries++;
        end
        if (!s_ready) check_val("s_ready_wait", {255'b0, s_ready}, 1);
        s_valid = 1'b1;
        s_id    = IW'(id);
        s_data  = DW'(ts);
        model_accept(id, ts, cyc);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < TO + 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check_val("wait_out_valid", 0, 1);
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (!s_ready) ready_low++;
            if (drop_err) obs_drops++;
            if (out_valid) begin
                frames_seen++;
                if (exp_q.size() == 0) begin
                    check_val("unexpected_out_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    last_exp = e;
                    check_val("ov_cycle", cyc, e.cyc);
                    check_val("frame_partial", {255'b0, frame_partial}, {255'b0, e.part});
                    check_val("min_indices", {244'b0, min_indices}, {244'b0, e.mins});
                    check_val("data_out", {64'b0, data_out}, {64'b0, e.data});
                end
            end
        end
    end

    logic [IW*NS-1:0] exp_oi;
    int perm [NS];

    initial begin
        int f;
        int hold_err;
        for (int i = 0; i < NS; i++) exp_oi[i*IW +: IW] = IW'(i);
        model_clear();

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_s_ready", {255'b0, s_ready}, 0);
        check_val("rst_data_out", {64'b0, data_out}, {64'b0, {NS{16'hFFFF}}});
        check_val("rst_min_indices", {244'b0, min_indices}, {244'b0, {N{4'hF}}});
        check_val("rst_out_indices", {208'b0, out_indices}, {208'b0, exp_oi});
        check_val("rst_flags", {253'b0, out_valid, frame_partial, drop_err}, 0);
        rst = 1'b0;
        #1;
        check_val("s_ready_after_rst", {255'b0, s_ready}, 1);

        // 1: full frame in id order
        for (int i = 0; i < NS; i++) send(i, 100 + 10 * i);
        wait_frame();
        check_val("t1_drops", obs_drops, exp_drops);

        // 2: out-of-range id while idle, then three hits and a timeout
        send(14, 7);
        send(5, 40);
        send(9, 20);
        send(2, 30);
        model_push(1, f_cyc + TO + 1);
        wait_frame();
        check_val("t2_drops", obs_drops, exp_drops);

        // 3: two hits only, one unfilled rank
        send(7, 60);
        send(3, 35);
        model_push(1, f_cyc + TO + 1);
        wait_frame();

        // 4: duplicate id and out-of-range id inside a frame
        send(4, 50);
        send(4, 10);
        send(13, 5);
        for (int i = 0; i < NS; i++) if (i != 4) send(i, 200 + i);
        wait_frame();
        check_val("t4_drops", obs_drops, exp_drops);
        check_val("t4_slot4", {240'b0, last_exp.data[4*DW +: DW]}, 50);

        // 5: equal timestamps, last sample lands on the timeout cycle
        send(8, 25);
        f = f_cyc;
        send(1, 25);
        while (cyc < f + TO - 10) begin
            @(posedge clk); #1;
        end
        foreach (perm[i]) perm[i] = i;
        for (int i = 0; i < NS; i++) if (i != 8 && i != 1) send(i, 500 + i);
        wait_frame();

        // 6: reset mid-frame, then a shuffled full frame
        for (int i = 0; i < 6; i++) send(i, 70 + i);
        @(posedge clk); #1;
        rst = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_val("midrst_data_out", {64'b0, data_out}, {64'b0, {NS{16'hFFFF}}});
        check_val("midrst_min_indices", {244'b0, min_indices}, {244'b0, {N{4'hF}}});
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) perm[i] = i;
        for (int i = NS - 1; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(0, i));
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int i = 0; i < NS; i++) send(perm[i], int'($urandom_range(0, 300)));
        wait_frame();

        hold_err = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (data_out !== last_exp.data || min_indices !== last_exp.mins ||
                frame_partial !== last_exp.part || out_valid !== 1'b0) hold_err++;
        end
        check_val("hold_stable", hold_err, 0);

        check_val("frames_seen", frames_seen, 6);
        check_val("ready_low_per_frame", ready_low, frames_seen);
        check_val("final_drops", obs_drops, exp_drops);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
